// File: rtl/dec3t8_grant.sv
// dec3t8_grant: registered 3-to-8 grant decoder.
// Accepts an encoded request {code_i, idle_i} over a valid/ready handshake,
// drives the matching one-hot grant line on O and holds it until done_i or
// until the hold timer expires. Then a single all-zero RELEASE cycle follows.
//
// Handshake: a request transfers on a rising edge where valid_i && ready_o.
// ready_o is a pure function of the state register (high only in IDLE), so
// it never depends on valid_i combinationally. Upstream must keep code_i,
// idle_i and valid_i stable while ready_o is low.
module dec3t8_grant #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_i,
    input  logic       idle_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       done_i,
    output logic [7:0] O,
    output logic       busy_o,
    output logic       timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Last legal GRANT count value; reaching it without done_i forces release.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [7:0]       o_q, o_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic accept;
    logic expire;

    // A transfer happens only in IDLE; expiry is judged on the current count.
    always_comb begin
        accept = valid_i && (state_q == ST_IDLE);
        expire = (cnt_q == CNT_LAST);
    end

    // State register plus registered outputs; reset drops the grant at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            o_q       <= 8'h00;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            o_q       <= o_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (accept && !idle_i) state_d = ST_GRANT;
                else                   state_d = ST_IDLE;
            end
            ST_GRANT: begin
                if (done_i || expire) state_d = ST_RELEASE;
                else                  state_d = ST_GRANT;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath: grant vector, saturating hold counter and timeout pulse.
    always_comb begin
        o_d       = 8'h00;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Every accept clears the counter; an idle request is simply dropped.
                if (accept) begin
                    cnt_d = '0;
                    if (!idle_i) o_d = 8'b0000_0001 << code_i;
                end
            end
            ST_GRANT: begin
                o_d   = o_q;
                cnt_d = expire ? cnt_q : cnt_q + 1'b1;
                if (done_i || expire) begin
                    // Grant drops on entry to RELEASE; done_i beats expiry.
                    o_d       = 8'h00;
                    timeout_d = !done_i;
                end
            end
            ST_RELEASE: begin
                o_d = 8'h00;
            end
            default: begin
                o_d   = 8'h00;
                cnt_d = '0;
            end
        endcase
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        ready_o   = (state_q == ST_IDLE);
        busy_o    = (state_q == ST_GRANT) || (state_q == ST_RELEASE);
        O         = o_q;
        timeout_o = timeout_q;
    end

    // The grant vector is at most one-hot, and non-zero only while granting.
    a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(o_q));
    a_zero_outside_grant : assert property (
        @(posedge clk) disable iff (rst) (state_q != ST_GRANT) |-> (o_q == 8'h00));

endmodule

// File: tb/tb_dec3t8_grant.sv
// Directed bench for dec3t8_grant: the driver pushes the hand-computed
// per-cycle response {O, ready_o, busy_o, timeout_o} into exp_q while it
// applies inputs; an independent monitor pops and compares on each falling edge.
module tb_dec3t8_grant;

  localparam int W = 11;

  logic       clk;
  logic       rst;
  logic [2:0] code_i;
  logic       idle_i;
  logic       valid_i;
  logic       ready_o;
  logic       done_i;
  logic [7:0] O;
  logic       busy_o;
  logic       timeout_o;

  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  int           chk_cnt;
  int           pass_cnt;
  int           step_no;

  dec3t8_grant #(.HOLD_MAX(15), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .code_i    (code_i),
    .idle_i    (idle_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .done_i    (done_i),
    .O         (O),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int tag, input logic [W-1:0] act,
                       input logic [W-1:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s step %0d: got O=%h rdy=%b busy=%b to=%b, want O=%h rdy=%b busy=%b to=%b",
                  name, tag, act[10:3], act[2], act[1], act[0],
                  expv[10:3], expv[2], expv[1], expv[0]);
  endtask

  // driver: apply inputs for one cycle and record the response expected this cycle
  task automatic step(input logic v, input logic idl, input logic [2:0] code, input logic dn,
                      input logic [7:0] eo, input logic er, input logic eb, input logic et);
    valid_i = v;
    idle_i  = idl;
    code_i  = code;
    done_i  = dn;
    exp_q.push_back({eo, er, eb, et});
    tag_q.push_back(step_no);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      int           t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check("cycle", t, {O, ready_o, busy_o, timeout_o}, e);
      chk_cnt++;
      if ($onehot0(O)) pass_cnt++;
      else $display("FAIL onehot step %0d: got O=%h, want at most one bit set", t, O);
    end
  end

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    step_no  = 0;
    rst      = 1'b1;
    valid_i  = 1'b0;
    idle_i   = 1'b0;
    code_i   = 3'd0;
    done_i   = 1'b0;
    @(posedge clk);
    #1;
    // reset state
    idle_cycle();
    idle_cycle();
    rst = 1'b0;
    idle_cycle();

    // code 5: grant 20, done two cycles later, one release cycle, back to idle
    step(1'b1, 1'b0, 3'd5, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle_cycle();

    // idle request is consumed and dropped
    step(1'b1, 1'b1, 3'd7, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd7, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle_cycle();

    // code 0 never done: 15 grant cycles (valid_i ignored), one timeout pulse
    step(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++)
      step(1'b1, 1'b0, 3'd6, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    idle_cycle();
    idle_cycle();

    // code 2: done on the 15th grant cycle beats expiry, no timeout
    step(1'b1, 1'b0, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++)
      step(1'b0, 1'b0, 3'd0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle_cycle();

    // back-to-back codes 3 then 6 held valid
    step(1'b1, 1'b0, 3'd3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 3'd6, 1'b1, 8'h08, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 3'd6, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 3'd6, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle_cycle();

    // async reset in the middle of a grant, checked without a clock edge
    step(1'b1, 1'b0, 3'd4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0);
    exp_q.push_back({8'h00, 1'b1, 1'b0, 1'b0});
    tag_q.push_back(step_no);
    step_no++;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", step_no - 1, {O, ready_o, busy_o, timeout_o}, {8'h00, 1'b1, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycle();
    idle_cycle();

    // everything pushed must have been compared
    @(negedge clk);
    #1;
    chk_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d entries left, want 0", exp_q.size());

    // final report
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
